// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU fetch path.
package cpu_pkg;

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    REFILL,
    UNCACHED,
    BYPASS,
    RESTART
  } icache_state_e;

  localparam logic [31:0] UNCACHED_BASE_ADDR = 32'hFFFF0000;
  localparam logic [31:0] RESET_VECTOR       = 32'hFFFF0000;

endpackage

// File: rtl/cpu_icache_ram.sv
// Simple dual-port RAM: one write port, one read port with registered address.
module cpu_icache_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0]         mem [DEPTH];
  logic [$clog2(DEPTH)-1:0] raddr_q;

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    raddr_q <= raddr;
  end

  assign rdata = mem[raddr_q];

endmodule

// File: rtl/cpu_icache.sv
// Direct-mapped read-only instruction cache with line refill and an uncached boot-ROM window.
module cpu_icache
  import cpu_pkg::*;
#(
  parameter int          LINES         = 64,
  parameter int          LINE_WORDS    = 4,
  parameter logic [31:0] UNCACHED_BASE = UNCACHED_BASE_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] p1_pc,
  input  logic        invalidate,
  output logic [31:0] instr_data,
  output logic        icache_stall,
  output logic        mem_request,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 32 - IW - OW - 2;

  icache_state_e state, state_n;

  logic [31:0]      lookup_addr, req_addr, held_addr, bypass_data;
  logic [LINES-1:0] valid;
  logic [IW-1:0]    flush_cnt;
  logic [OW-1:0]    beat;
  logic             flush_pending;
  logic [31:0]      ram_q;
  logic [TW-1:0]    tag_q;
  logic             hit, req_uncached, data_we, tag_we, flush_req;

  wire [IW-1:0] req_idx  = req_addr[OW+2 +: IW];
  wire [TW-1:0] req_tag  = req_addr[31 -: TW];
  wire [IW-1:0] held_idx = held_addr[OW+2 +: IW];
  wire [TW-1:0] held_tag = held_addr[31 -: TW];

  logic unused_bits;
  assign unused_bits = ^{lookup_addr[1:0], req_addr[1:0], held_addr[OW+1:0]};

  // The PC stage only advances in IDLE and BYPASS; otherwise keep re-reading the held miss.
  assign lookup_addr  = (state == IDLE || state == BYPASS) ? p1_pc : held_addr;
  assign req_uncached = (req_addr >= UNCACHED_BASE);
  assign hit          = !req_uncached && valid[req_idx] && (tag_q == req_tag);
  assign data_we      = (state == REFILL) && mem_ack;
  assign tag_we       = data_we && (beat == '1);
  assign flush_req    = flush_pending || invalidate;

  cpu_icache_ram #(.DEPTH(LINES*LINE_WORDS), .WIDTH(32)) u_data (
    .clock (clock),
    .we    (data_we),
    .waddr ({held_idx, beat}),
    .wdata (mem_rdata),
    .raddr (lookup_addr[IW+OW+1:2]),
    .rdata (ram_q)
  );

  cpu_icache_ram #(.DEPTH(LINES), .WIDTH(TW)) u_tag (
    .clock (clock),
    .we    (tag_we),
    .waddr (held_idx),
    .wdata (held_tag),
    .raddr (lookup_addr[OW+2 +: IW]),
    .rdata (tag_q)
  );

  always_comb begin
    state_n = state;
    case (state)
      FLUSH:    if (flush_cnt == '1) state_n = RESTART;
      IDLE: begin
        if (invalidate) state_n = FLUSH;
        else if (!hit)  state_n = req_uncached ? UNCACHED : REFILL;
      end
      REFILL:   if (tag_we)  state_n = flush_req ? FLUSH : RESTART;
      UNCACHED: if (mem_ack) state_n = flush_req ? FLUSH : BYPASS;
      BYPASS:   state_n = invalidate ? FLUSH : IDLE;
      RESTART:  state_n = invalidate ? FLUSH : IDLE;
      default:  state_n = FLUSH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= FLUSH;
      flush_cnt     <= '0;
      beat          <= '0;
      flush_pending <= 1'b0;
      mem_request   <= 1'b0;
      mem_addr      <= '0;
      held_addr     <= RESET_VECTOR;
      bypass_data   <= '0;
    end else begin
      state       <= state_n;
      mem_request <= (state_n == REFILL) || (state_n == UNCACHED);
      if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
      if (data_we) beat <= beat + 1'b1;
      if (state == UNCACHED && mem_ack) bypass_data <= mem_rdata;

      if (state_n == FLUSH) flush_pending <= 1'b0;
      else if (invalidate && (state == REFILL || state == UNCACHED)) flush_pending <= 1'b1;

      // On invalidate, remember whichever fetch still owes the pipeline a word.
      if (state == IDLE) begin
        if (invalidate)  held_addr <= hit ? p1_pc : req_addr;
        else if (!hit)   held_addr <= req_addr;
      end else if (state == BYPASS && invalidate) begin
        held_addr <= p1_pc;
      end

      if (state == IDLE && state_n == REFILL)
        mem_addr <= {req_addr[31:OW+2], {(OW+2){1'b0}}};
      else if (state == IDLE && state_n == UNCACHED)
        mem_addr <= {req_addr[31:2], 2'b00};
      else if (data_we)
        mem_addr <= {held_addr[31:OW+2], beat + 1'b1, 2'b00};
    end
  end

  always_ff @(posedge clock) req_addr <= lookup_addr;

  always_ff @(posedge clock) begin
    if (state == FLUSH) valid[flush_cnt] <= 1'b0;
    else if (tag_we)    valid[held_idx]  <= 1'b1;
  end

  assign icache_stall = !((state == IDLE && hit) || state == BYPASS);
  assign instr_data   = (state == BYPASS) ? bypass_data :
                        (state == IDLE)   ? ram_q       : 32'h0;

endmodule
